// File: rtl/mem_stage_bytelane.sv
// mem_stage_bytelane
// MEM pipeline stage of the MIPS core, sitting between instruction_execute
// and write-back. It holds a byte-lane data memory of 2^NB_ADDR 32-bit words
// and performs byte/half/word loads and stores, little-endian, with sign or
// zero extension on loads. Misaligned accesses are detected and suppressed.
// Stall/halt freeze the stage, flush injects a bubble, and a registered debug
// port lets the memory be dumped while the core is halted.
//
// Ports:
//   clk, i_rst_n                 clock, asynchronous active-low reset
//   i_stall, i_halt, i_flush     pipeline control
//   i_reg2write, i_result        destination register, ALU result / byte address
//   i_data4Mem                   store data
//   i_width, i_sign_flag         access width (00 b, 01 h, 10 w, 11 illegal), load extension
//   i_mem2reg, i_memRead,
//   i_memWrite, i_regWrite       control signals from EX
//   i_dbg_addr                   debug word address
//   o_reg_read                   extended load data (registered)
//   o_ALUresult, o_reg2write     registered pass-through
//   o_mem2reg, o_regWrite        registered control
//   o_misaligned, o_exc_sticky   misalignment pulse and sticky exception flag
//   o_dbg_data                   registered mem[i_dbg_addr]
module mem_stage_bytelane #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8,
    parameter int NB_REG  = 5
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_halt,
    input  logic               i_flush,
    input  logic [NB_REG-1:0]  i_reg2write,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic               i_mem2reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_reg_read,
    output logic [NB_DATA-1:0] o_ALUresult,
    output logic [NB_REG-1:0]  o_reg2write,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic               o_misaligned,
    output logic               o_exc_sticky,
    output logic [NB_DATA-1:0] o_dbg_data
);

    localparam int DEPTH = 1 << NB_ADDR;

    logic [NB_DATA-1:0] mem [DEPTH];

    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         offset;
    logic               hold;
    logic               misaligned;
    logic               write_en;
    logic [3:0]         byte_en;
    logic [NB_DATA-1:0] wr_data;
    logic [NB_DATA-1:0] rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [NB_DATA-1:0] load_data;

    // Address bits above the word index are deliberately ignored so the
    // address wraps around the array; this reduction only marks them as
    // intentionally unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_result[NB_DATA-1:NB_ADDR+2];

    assign word_idx = i_result[NB_ADDR+1:2];
    assign offset   = i_result[1:0];
    assign hold     = i_stall | i_halt;
    assign rd_word  = mem[word_idx];

    // Alignment check: halves need an even offset, words need offset 0 and
    // width 11 is never legal. Only memory instructions can be misaligned.
    always_comb begin
        misaligned = 1'b0;
        if (i_memRead || i_memWrite) begin
            case (i_width)
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = offset[0];
                2'b10:   misaligned = |offset;
                default: misaligned = 1'b1;
            endcase
        end
    end

    // Store lane enables and lane-replicated write data. Replicating the
    // source across lanes means each enabled lane picks up the right bits
    // without a shifter. Reset is folded into the enable so a store
    // presented while reset is asserted is lost.
    always_comb begin
        byte_en = 4'b0000;
        wr_data = i_data4Mem;
        case (i_width)
            2'b00: begin
                byte_en = 4'b0001 << offset;
                wr_data = {4{i_data4Mem[7:0]}};
            end
            2'b01: begin
                byte_en = offset[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{i_data4Mem[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wr_data = i_data4Mem;
            end
            default: begin
                byte_en = 4'b0000;
                wr_data = i_data4Mem;
            end
        endcase
    end

    assign write_en = i_memWrite & ~misaligned & ~hold & ~i_flush & i_rst_n;

    // Load path: pick the addressed byte or half from the combinational read
    // and extend it. The read sees the array before this edge's store, so a
    // combined read+write returns the old contents.
    always_comb begin
        rd_byte   = 8'h00;
        rd_half   = 16'h0000;
        load_data = '0;
        case (offset)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = offset[1] ? rd_word[31:16] : rd_word[15:0];
        if (i_memRead && !misaligned) begin
            case (i_width)
                2'b00:   load_data = {{24{i_sign_flag & rd_byte[7]}}, rd_byte};
                2'b01:   load_data = {{16{i_sign_flag & rd_half[15]}}, rd_half};
                default: load_data = rd_word;
            endcase
        end
    end

    // Data memory array. It has no reset so its contents survive a core
    // reset; only the lanes selected by byte_en are updated.
    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Stage output registers. Stall/halt freeze everything except the
    // misalignment pulse, which drops to 0 so it is never seen twice.
    // Flush loads a bubble. A misaligned instruction still moves through
    // but cannot write the register file.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_reg_read   <= '0;
            o_ALUresult  <= '0;
            o_reg2write  <= '0;
            o_mem2reg    <= 1'b0;
            o_regWrite   <= 1'b0;
            o_misaligned <= 1'b0;
        end else if (hold) begin
            o_misaligned <= 1'b0;
        end else if (i_flush) begin
            o_reg_read   <= '0;
            o_ALUresult  <= '0;
            o_reg2write  <= '0;
            o_mem2reg    <= 1'b0;
            o_regWrite   <= 1'b0;
            o_misaligned <= 1'b0;
        end else begin
            o_reg_read   <= load_data;
            o_ALUresult  <= i_result;
            o_reg2write  <= i_reg2write;
            o_mem2reg    <= i_mem2reg;
            o_regWrite   <= i_regWrite & ~misaligned;
            o_misaligned <= misaligned;
        end
    end

    // Sticky exception flag: set by any misaligned instruction that actually
    // retires through this stage, cleared only by reset.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_exc_sticky <= 1'b0;
        end else if (!hold && !i_flush && misaligned) begin
            o_exc_sticky <= 1'b1;
        end
    end

    // Debug read port, sampled every cycle independent of stall/halt so the
    // memory can be dumped while the core is frozen.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dbg_data <= '0;
        end else begin
            o_dbg_data <= mem[i_dbg_addr];
        end
    end

endmodule

// File: tb/tb_mem_stage_bytelane.sv
// tb_mem_stage_bytelane
// Directed bench for mem_stage_bytelane: stores and loads of every width,
// sign/zero extension, misalignment handling, stall/flush/halt, debug port,
// address wrap and asynchronous reset with memory retention.
module tb_mem_stage_bytelane;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall, i_halt, i_flush;
    logic [4:0]  i_reg2write;
    logic [31:0] i_result, i_data4Mem;
    logic [1:0]  i_width;
    logic        i_sign_flag, i_mem2reg, i_memRead, i_memWrite, i_regWrite;
    logic [7:0]  i_dbg_addr;
    logic [31:0] o_reg_read, o_ALUresult, o_dbg_data;
    logic [4:0]  o_reg2write;
    logic        o_mem2reg, o_regWrite, o_misaligned, o_exc_sticky;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] W_B = 2'b00;
    localparam logic [1:0] W_H = 2'b01;
    localparam logic [1:0] W_W = 2'b10;

    mem_stage_bytelane #(.NB_DATA(32), .NB_ADDR(8), .NB_REG(5)) dut (
        .clk(clk), .i_rst_n(i_rst_n),
        .i_stall(i_stall), .i_halt(i_halt), .i_flush(i_flush),
        .i_reg2write(i_reg2write), .i_result(i_result), .i_data4Mem(i_data4Mem),
        .i_width(i_width), .i_sign_flag(i_sign_flag),
        .i_mem2reg(i_mem2reg), .i_memRead(i_memRead),
        .i_memWrite(i_memWrite), .i_regWrite(i_regWrite),
        .i_dbg_addr(i_dbg_addr),
        .o_reg_read(o_reg_read), .o_ALUresult(o_ALUresult),
        .o_reg2write(o_reg2write), .o_mem2reg(o_mem2reg),
        .o_regWrite(o_regWrite), .o_misaligned(o_misaligned),
        .o_exc_sticky(o_exc_sticky), .o_dbg_data(o_dbg_data)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Drive one instruction into the stage, clock it in and sample 1 ns
    // after the edge.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [1:0] w, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] rg, input logic rw,
                                 input logic m2r);
        i_memRead   = rd;
        i_memWrite  = wr;
        i_width     = w;
        i_sign_flag = sgn;
        i_result    = addr;
        i_data4Mem  = data;
        i_reg2write = rg;
        i_regWrite  = rw;
        i_mem2reg   = m2r;
        @(posedge clk);
        #1;
    endtask

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Directed sequence of steps with hand-computed expectations.
    initial begin
        i_rst_n = 1'b0;
        i_stall = 1'b0;
        i_halt  = 1'b0;
        i_flush = 1'b0;
        i_dbg_addr = 8'h00;
        i_memRead = 1'b0; i_memWrite = 1'b0; i_width = W_W; i_sign_flag = 1'b0;
        i_result = '0; i_data4Mem = '0; i_reg2write = '0; i_regWrite = 1'b0;
        i_mem2reg = 1'b0;
        #3;
        checkOutput("rst_reg_read", o_reg_read, 32'h0);
        checkOutput("rst_alu", o_ALUresult, 32'h0);
        checkOutput("rst_regwrite", {31'h0, o_regWrite}, 32'h0);
        checkOutput("rst_sticky", {31'h0, o_exc_sticky}, 32'h0);
        checkOutput("rst_dbg", o_dbg_data, 32'h0);
        @(negedge clk);
        i_rst_n = 1'b1;

        $display("[TB] word store/load");
        applyStimulus(0, 1, W_W, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0);
        checkOutput("sw_alu", o_ALUresult, 32'h10);
        checkOutput("sw_misaligned", {31'h0, o_misaligned}, 32'h0);
        applyStimulus(1, 0, W_W, 0, 32'h10, 32'h0, 5'd5, 1, 1);
        checkOutput("lw_10", o_reg_read, 32'hDEADBEEF);
        checkOutput("lw_reg2write", {27'h0, o_reg2write}, 32'd5);
        checkOutput("lw_regwrite", {31'h0, o_regWrite}, 32'h1);
        checkOutput("lw_mem2reg", {31'h0, o_mem2reg}, 32'h1);

        $display("[TB] byte store/loads");
        applyStimulus(0, 1, W_B, 0, 32'h13, 32'h00000080, 5'd0, 0, 0);
        applyStimulus(1, 0, W_B, 1, 32'h13, 32'h0, 5'd1, 1, 1);
        checkOutput("lb_13", o_reg_read, 32'hFFFFFF80);
        applyStimulus(1, 0, W_B, 0, 32'h13, 32'h0, 5'd1, 1, 1);
        checkOutput("lbu_13", o_reg_read, 32'h00000080);
        applyStimulus(1, 0, W_W, 0, 32'h10, 32'h0, 5'd1, 1, 1);
        checkOutput("lw_10_after_sb", o_reg_read, 32'h80ADBEEF);

        $display("[TB] half store/loads");
        applyStimulus(0, 1, W_W, 0, 32'h14, 32'hCAFEF00D, 5'd0, 0, 0);
        applyStimulus(0, 1, W_H, 0, 32'h16, 32'h00001234, 5'd0, 0, 0);
        applyStimulus(1, 0, W_H, 1, 32'h16, 32'h0, 5'd2, 1, 1);
        checkOutput("lh_16", o_reg_read, 32'h00001234);
        applyStimulus(1, 0, W_W, 0, 32'h14, 32'h0, 5'd2, 1, 1);
        checkOutput("lw_14_after_sh", o_reg_read, 32'h1234F00D);
        applyStimulus(0, 1, W_H, 0, 32'h18, 32'h00008001, 5'd0, 0, 0);
        applyStimulus(1, 0, W_H, 1, 32'h18, 32'h0, 5'd3, 1, 1);
        checkOutput("lh_18_signed", o_reg_read, 32'hFFFF8001);
        applyStimulus(1, 0, W_H, 0, 32'h18, 32'h0, 5'd3, 1, 1);
        checkOutput("lhu_18", o_reg_read, 32'h00008001);

        $display("[TB] misaligned accesses");
        applyStimulus(0, 1, W_W, 0, 32'h20, 32'h11223344, 5'd0, 0, 0);
        applyStimulus(0, 1, W_W, 0, 32'h21, 32'h55555555, 5'd4, 1, 0);
        checkOutput("mis_sw_pulse", {31'h0, o_misaligned}, 32'h1);
        checkOutput("mis_sw_regwrite", {31'h0, o_regWrite}, 32'h0);
        checkOutput("mis_sw_sticky", {31'h0, o_exc_sticky}, 32'h1);
        applyStimulus(1, 0, W_W, 0, 32'h20, 32'h0, 5'd4, 1, 1);
        checkOutput("mis_mem_unchanged", o_reg_read, 32'h11223344);
        checkOutput("mis_pulse_cleared", {31'h0, o_misaligned}, 32'h0);
        checkOutput("mis_sticky_held", {31'h0, o_exc_sticky}, 32'h1);
        applyStimulus(1, 0, W_H, 1, 32'h17, 32'h0, 5'd6, 1, 1);
        checkOutput("mis_lh_data", o_reg_read, 32'h0);
        checkOutput("mis_lh_regwrite", {31'h0, o_regWrite}, 32'h0);
        checkOutput("mis_lh_pulse", {31'h0, o_misaligned}, 32'h1);

        $display("[TB] stall");
        applyStimulus(0, 1, W_W, 0, 32'h30, 32'h0BADC0DE, 5'd0, 0, 0);
        applyStimulus(1, 0, W_W, 0, 32'h10, 32'h0, 5'd7, 1, 1);
        i_stall = 1'b1;
        i_dbg_addr = 8'h0C;
        applyStimulus(0, 1, W_W, 0, 32'h30, 32'hAAAAAAAA, 5'd9, 1, 0);
        checkOutput("stall_dbg_0c", o_dbg_data, 32'h0BADC0DE);
        checkOutput("stall_alu_held", o_ALUresult, 32'h10);
        checkOutput("stall_data_held", o_reg_read, 32'h80ADBEEF);
        checkOutput("stall_reg_held", {27'h0, o_reg2write}, 32'd7);
        applyStimulus(0, 1, W_W, 0, 32'h31, 32'hAAAAAAAA, 5'd9, 1, 0);
        checkOutput("stall_no_pulse", {31'h0, o_misaligned}, 32'h0);
        checkOutput("stall_dbg_again", o_dbg_data, 32'h0BADC0DE);
        i_stall = 1'b0;

        $display("[TB] flush");
        i_flush = 1'b1;
        applyStimulus(1, 0, W_W, 0, 32'h10, 32'h0, 5'd8, 1, 1);
        checkOutput("flush_regwrite", {31'h0, o_regWrite}, 32'h0);
        checkOutput("flush_alu", o_ALUresult, 32'h0);
        checkOutput("flush_data", o_reg_read, 32'h0);
        checkOutput("flush_sticky", {31'h0, o_exc_sticky}, 32'h1);
        i_flush = 1'b0;

        $display("[TB] halt with debug read");
        i_halt = 1'b1;
        i_dbg_addr = 8'h04;
        applyStimulus(0, 1, W_W, 0, 32'h10, 32'h0, 5'd9, 1, 0);
        checkOutput("halt_dbg_04", o_dbg_data, 32'h80ADBEEF);
        checkOutput("halt_alu_held", o_ALUresult, 32'h0);
        applyStimulus(0, 1, W_W, 0, 32'h10, 32'h0, 5'd9, 1, 0);
        checkOutput("halt_no_write", o_dbg_data, 32'h80ADBEEF);
        i_halt = 1'b0;

        $display("[TB] combined read/write, wrap, non-memory op");
        applyStimulus(1, 1, W_W, 0, 32'h10, 32'h00000000, 5'd10, 1, 1);
        checkOutput("rw_prewrite", o_reg_read, 32'h80ADBEEF);
        applyStimulus(1, 0, W_W, 0, 32'h10, 32'h0, 5'd10, 1, 1);
        checkOutput("rw_written", o_reg_read, 32'h00000000);
        applyStimulus(1, 0, W_W, 0, 32'h414, 32'h0, 5'd11, 1, 1);
        checkOutput("wrap_414", o_reg_read, 32'h1234F00D);
        applyStimulus(0, 0, W_W, 0, 32'h1234, 32'hFFFFFFFF, 5'd12, 1, 0);
        checkOutput("nop_data", o_reg_read, 32'h0);
        checkOutput("nop_alu", o_ALUresult, 32'h1234);
        checkOutput("nop_regwrite", {31'h0, o_regWrite}, 32'h1);

        $display("[TB] asynchronous reset mid-run");
        @(negedge clk);
        i_rst_n = 1'b0;
        #1;
        checkOutput("arst_alu", o_ALUresult, 32'h0);
        checkOutput("arst_regwrite", {31'h0, o_regWrite}, 32'h0);
        checkOutput("arst_sticky", {31'h0, o_exc_sticky}, 32'h0);
        checkOutput("arst_dbg", o_dbg_data, 32'h0);
        i_memRead = 1'b0; i_memWrite = 1'b0; i_regWrite = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        applyStimulus(1, 0, W_W, 0, 32'h14, 32'h0, 5'd13, 1, 1);
        checkOutput("retained_14", o_reg_read, 32'h1234F00D);
        checkOutput("retained_sticky", {31'h0, o_exc_sticky}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mem_stage_bytelane.md
# mem_stage_bytelane

Parametrised MEM pipeline stage for the MIPS core, placed between instruction_execute and write-back. It contains a byte-lane-enabled data memory of 2^NB_ADDR words and supports byte, halfword and word loads and stores, with correct lane selection from the byte address and sign/zero extension. It detects misaligned accesses and suppresses them, honours stall, halt and flush, and exposes a registered debug read port for dumping memory while halted.

## Interface
- NB_DATA, 32, datapath width; fixed at 32 (4 byte lanes).
- NB_ADDR, 8, word-address bits; memory depth is 2^NB_ADDR words.
- NB_REG, 5, register-index width.
- clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_stall  in  1  hold all stage registers; suppress the memory write.
- i_halt  in  1  same effect as i_stall; the debug port is usable.
- i_flush  in  1  kill the current instruction; load a bubble.
- i_reg2write  in  NB_REG  destination register.
- i_result  in  NB_DATA  ALU result, used as the byte address for memory operations.
- i_data4Mem  in  NB_DATA  store source data.
- i_width  in  2  access width: 00 byte, 01 half, 10 word, 11 illegal.
- i_sign_flag  in  1  load extension: 1 sign-extend, 0 zero-extend.
- i_mem2reg, i_memRead, i_memWrite, i_regWrite  in  1 each  control signals.
- i_dbg_addr  in  NB_ADDR  debug word address.
- o_reg_read  out  NB_DATA  extended load data.
- o_ALUresult  out  NB_DATA  registered i_result.
- o_reg2write  out  NB_REG  registered destination register.
- o_mem2reg, o_regWrite  out  1 each  registered control signals.
- o_misaligned  out  1  one-cycle pulse: the instruction just registered was misaligned.
- o_exc_sticky  out  1  set by any misaligned access; cleared only by reset.
- o_dbg_data  out  NB_DATA  mem[i_dbg_addr], registered.

## Operation
- Address decode:
  - word index = i_result[NB_ADDR+1:2]; address bits above this range are ignored (address wraps).
  - byte offset = i_result[1:0].
- Misaligned: the access is misaligned when (i_memRead or i_memWrite) and one of the following holds:
  - half access with offset[0]=1;
  - word access with offset≠0;
  - i_width=11.
- Store (i_memWrite=1, aligned, no stall/halt/flush):
  - byte: writes lane=offset with i_data4Mem[7:0].
  - half: writes lanes {offset[1],0}..{offset[1],1} with i_data4Mem[15:0].
  - word: writes all four lanes.
  - Unselected lanes are unchanged. Little-endian: lane 0 = bits [7:0].
- Load: the combinational read of mem[word index] selects the lane(s) by offset, then extends to 32 bits per i_sign_flag. Word loads ignore i_sign_flag.
- A misaligned access causes all of the following:
  - no memory write;
  - load data forced to 0;
  - o_regWrite registered as 0;
  - o_misaligned=1 for one cycle;
  - o_exc_sticky set.
- i_memRead and i_memWrite both 1: treated as a store. o_reg_read carries the pre-write contents.
- Non-memory instruction (both 0): o_reg_read=0; o_ALUresult passes through.
- Priority: reset > (stall|halt) > flush > normal.
  - Stall/halt: every output register holds; no write; o_misaligned=0.
  - Flush: outputs load a bubble (all 0); no write; the sticky flag is unchanged.
- Debug port: o_dbg_data <= mem[i_dbg_addr] every cycle regardless of halt. Reads are non-destructive.
- Memory array contents are not cleared by reset.

## Timing
- Reset (asynchronous): every output = 0, including o_exc_sticky and o_dbg_data.
- Stage latency: 1 cycle. Inputs present before edge N appear on outputs after edge N.
- A store takes effect at its edge. A load issued the next cycle to the same word returns the new data (no hazard).
- Debug read latency: 1 cycle after i_dbg_addr is stable.
- Reset asserted during a stall or write: the write is lost if reset is asserted before the edge. The array is otherwise intact.
- Stall released: normal processing resumes on the next edge using the current inputs. Held inputs are the upstream stage's responsibility.

## Test plan
- Store word 0xDEADBEEF at address 0x10, then load word 0x10 -> o_reg_read=0xDEADBEEF one cycle after the load's edge.
- Store byte 0x80 at 0x13, then lb 0x13 signed -> 0xFFFFFF80; lbu -> 0x00000080; lw 0x10 -> 0x80ADBEEF.
- Store half 0x1234 at 0x16, then lh 0x16 -> 0x00001234; lw 0x14 upper half = 0x1234, lower half unchanged.
- Word store to 0x21 -> memory unchanged, o_misaligned pulses 1, o_regWrite=0, o_exc_sticky stays 1 until i_rst_n=0.
- i_stall=1 with a store of 0xAAAAAAAA to 0x30 -> debug read of word 0x0C unchanged; outputs held. Flush with i_regWrite=1 -> o_regWrite=0, o_ALUresult=0.
- i_halt=1, i_dbg_addr=4 after word 0x10 was written -> o_dbg_data=0x80ADBEEF next cycle. Asynchronous reset mid-run -> all outputs 0 immediately.
